// File: rtl/keypad_pkg.sv
// Shared types for the hex keypad entry block: FSM states, scan-result encoding, key map.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_kind_e;

    typedef struct packed {
        scan_kind_e kind;
        logic [3:0] code;
    } scan_res_t;

    localparam scan_res_t RES_NONE  = '{kind: SCAN_NONE,  code: 4'h0};
    localparam scan_res_t RES_MULTI = '{kind: SCAN_MULTI, code: 4'h0};

    // Nibble i holds the code for index {col,row}; column 0 rows are 1,4,7,0 and so on.
    localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

    function automatic logic [3:0] key_lookup(input logic [1:0] col_idx, input logic [1:0] row_idx);
        logic [5:0] base;
        base = {col_idx, row_idx, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

    // Combine two partial scan results: any two presses anywhere make the scan ambiguous.
    function automatic scan_res_t merge_res(input scan_res_t a, input scan_res_t b);
        scan_res_t r;
        if (a.kind == SCAN_NONE) begin
            r = b;
        end else if (b.kind == SCAN_NONE) begin
            r = a;
        end else begin
            r = RES_MULTI;
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column scan timing: divider, column index, active-low column drive, sample and scan-done strobes.
// Latency: strobes are combinational from the divider/index flops; col follows the index flop.
// Backpressure: none; free-running once out of reset.
module keypad_scan_timer
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 99999
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [3:0] col,
    output logic [1:0] col_idx,
    output logic       sample,
    output logic       scan_done
);

    localparam int                DIV_W   = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(SCAN_DIV);
    localparam logic [DIV_W-1:0]  DIV_ONE = DIV_W'(1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;

    // Divider wraps at DIV_MAX; the wrap cycle is the row sample point and advances the column.
    always_comb begin
        sample    = (div_q == DIV_MAX);
        scan_done = sample && (idx_q == 2'd3);
        div_d     = sample ? '0 : (div_q + DIV_ONE);
        idx_d     = sample ? (idx_q + 2'd1) : idx_q;
        col       = ~(4'b0001 << idx_q);
        col_idx   = idx_q;
    end

    // Divider and column index registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_q <= '0;
            idx_q <= 2'd0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce, shifting each accepted key into a 32-bit entry register.
// Latency: key_valid/data update 1 cycle after the column-3 sample edge that completes acceptance.
// Backpressure: none; key_valid is a one-cycle strobe that must be consumed when it fires.
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 99999,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clear,
    output logic [31:0] data,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
);

    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    logic [3:0]  row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [1:0]  col_idx;
    logic        sample, scan_done;
    logic [3:0]  row_low;
    logic [1:0]  row_idx;
    scan_res_t   col_res, scan_res, acc_q, acc_d;
    kp_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]  cand_q, cand_d;
    logic        accept_q, accept_d;
    logic        key_valid_q, key_valid_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_held_q, key_held_d;
    logic [31:0] data_q, data_d;

    keypad_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .col       (col),
        .col_idx   (col_idx),
        .sample    (sample),
        .scan_done (scan_done)
    );

    // Two-flop synchronizer for the asynchronous row inputs.
    always_comb begin
        row_s1_d = row;
        row_s2_d = row_s1_q;
    end

    // Decode the current column and fold it into the running result; column 0 starts a fresh scan.
    always_comb begin
        row_low = ~row_s2_q;
        row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_low[r]) row_idx = 2'(r);
        end
        col_res = RES_NONE;
        case ($countones(row_low))
            0:       col_res = RES_NONE;
            1:       col_res = '{kind: SCAN_SINGLE, code: key_lookup(col_idx, row_idx)};
            default: col_res = RES_MULTI;
        endcase
        scan_res = merge_res((col_idx == 2'd0) ? RES_NONE : acc_q, col_res);
        acc_d    = sample ? scan_res : acc_q;
    end

    // Debounce FSM, stepped once per completed scan; rollover keys are ignored until a release.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        accept_d = 1'b0;
        cnt_inc  = cnt_q + 4'd1;
        if (scan_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_res.kind == SCAN_SINGLE) begin
                        cand_d = scan_res.code;
                        cnt_d  = 4'd1;
                        if (DB_N == 4'd1) begin
                            state_d  = ST_HELD;
                            accept_d = 1'b1;
                        end else begin
                            state_d = ST_PRESS_DB;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (scan_res.kind == SCAN_SINGLE) begin
                        if (scan_res.code == cand_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == DB_N) begin
                                state_d  = ST_HELD;
                                accept_d = 1'b1;
                            end
                        end else begin
                            cand_d = scan_res.code;
                            cnt_d  = 4'd1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                ST_HELD: begin
                    if (scan_res.kind == SCAN_NONE) begin
                        if (DB_N == 4'd1) begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = ST_REL_DB;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                ST_REL_DB: begin
                    if (scan_res.kind == SCAN_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_N) begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Output stage: the accept strobe lands one cycle later; clear is applied before the shift.
    always_comb begin
        key_valid_d = accept_q;
        key_code_d  = accept_q ? cand_q : key_code_q;
        data_d      = clear ? 32'h0 : data_q;
        if (accept_q) begin
            data_d = {data_d[27:0], cand_q};
        end
        key_held_d = key_held_q;
        if (accept_d) begin
            key_held_d = 1'b1;
        end else if (state_q == ST_IDLE) begin
            key_held_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            acc_q       <= RES_NONE;
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cand_q      <= 4'h0;
            accept_q    <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
            data_q      <= 32'h0;
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            acc_q       <= acc_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            accept_q    <= accept_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            data_q      <= data_d;
        end
    end

    assign data      = data_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry with a behavioural 4x4 keypad and a key-strobe scoreboard.
// Latency: scan of 16 cycles (SCAN_DIV=3), two-scan debounce.
// Backpressure: n/a.
module tb_hex_keypad_entry;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [31:0] data;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;
    logic [31:0] exp_data;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_pulses = 0;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] dat;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    hex_keypad_entry #(
        .SCAN_DIV       (3),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .row       (row),
        .col       (col),
        .clear     (clear),
        .data      (data),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Keypad layout as printed on the part: columns left to right, rows top to bottom.
    function automatic logic [3:0] tb_code(input int c, input int r);
        case (c * 4 + r)
            0: return 4'h1;   1: return 4'h4;   2: return 4'h7;   3: return 4'h0;
            4: return 4'h2;   5: return 4'h5;   6: return 4'h8;   7: return 4'hF;
            8: return 4'h3;   9: return 4'h6;  10: return 4'h9;  11: return 4'hE;
           12: return 4'hA;  13: return 4'hB;  14: return 4'hC;  default: return 4'hD;
        endcase
    endfunction

    function automatic logic [15:0] kbit(input int k);
        return 16'(1) << k;
    endfunction

    // Pressed switches pull their row low while their column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[tb_code(c, r)]) row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic expect_key(input logic [3:0] k, input bit clr_same);
        exp_t e;
        exp_data = clr_same ? {28'h0, k} : {exp_data[27:0], k};
        e.code   = k;
        e.dat    = exp_data;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [15:0] mask, input int scans);
        pressed = mask;
        repeat (scans * 16) @(negedge clock);
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        exp_data = 32'h0;
    endtask

    // Return half a cycle after a new scan (column 0) begins.
    task automatic sync_scan();
        int guard;
        guard = 0;
        while (col !== 4'b0111 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        while (col !== 4'b1110 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) check_val("sync_timeout", 32'(guard), 32'd0);
    endtask

    task automatic enter_key(input int k);
        expect_key(4'(k), 1'b0);
        hold(kbit(k), 4);
        hold(16'h0, 4);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && key_valid === 1'b1) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", {28'h0, key_code}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("sb_key_code", {28'h0, key_code}, {28'h0, mon_e.code});
                check_val("sb_data", data, mon_e.dat);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int guard;
        int n;
        reset_n  = 1'b0;
        clear    = 1'b0;
        pressed  = 16'h0;
        exp_data = 32'h0;
        repeat (3) @(negedge clock);
        check_val("rst_col", {28'h0, col}, 32'hE);
        check_val("rst_data", data, 32'h0);
        check_val("rst_key_code", {28'h0, key_code}, 32'h0);
        check_val("rst_key_valid", {31'h0, key_valid}, 32'h0);
        check_val("rst_key_held", {31'h0, key_held}, 32'h0);
        reset_n = 1'b1;

        // Single key "8"
        p0 = n_pulses;
        expect_key(4'h8, 1'b0);
        hold(kbit(8), 4);
        check_val("k8_held", {31'h0, key_held}, 32'h1);
        check_val("k8_pulses", 32'(n_pulses - p0), 32'd1);
        check_val("k8_code", {28'h0, key_code}, 32'h8);
        check_val("k8_data", data, 32'h8);
        hold(16'h0, 4);
        check_val("k8_released", {31'h0, key_held}, 32'h0);

        // Nine keys with release in between, then clear
        p0 = n_pulses;
        for (int k = 1; k <= 9; k++) enter_key(k);
        check_val("seq_pulses", 32'(n_pulses - p0), 32'd9);
        check_val("seq_data", data, 32'h2345_6789);
        pulse_clear();
        check_val("clear_data", data, 32'h0);
        check_val("clear_keeps_code", {28'h0, key_code}, 32'h9);

        // Bounces
        p0 = n_pulses;
        sync_scan();
        hold(kbit(5), 1);
        hold(16'h0, 3);
        check_val("bounce5_pulses", 32'(n_pulses - p0), 32'd0);
        check_val("bounce5_held", {31'h0, key_held}, 32'h0);
        sync_scan();
        expect_key(4'h3, 1'b0);
        hold(kbit(14), 1);
        hold(kbit(3), 4);
        hold(16'h0, 4);
        check_val("e_then_3_pulses", 32'(n_pulses - p0), 32'd1);

        // Multiple keys and rollover
        p0 = n_pulses;
        hold(kbit(1) | kbit(10), 5);
        hold(16'h0, 4);
        check_val("multi_pulses", 32'(n_pulses - p0), 32'd0);
        expect_key(4'h1, 1'b0);
        hold(kbit(1), 4);
        hold(kbit(1) | kbit(10), 3);
        hold(16'h0, 4);
        check_val("rollover_pulses", 32'(n_pulses - p0), 32'd1);
        check_val("rollover_held", {31'h0, key_held}, 32'h0);

        // Clear coinciding with the strobe of "F"
        pulse_clear();
        for (int k = 1; k <= 8; k++) enter_key(k);
        check_val("pre_f_data", data, 32'h1234_5678);
        expect_key(4'hF, 1'b1);
        pressed = kbit(15);
        guard = 0;
        while (key_held !== 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check_val("f_held_wait", {31'h0, key_held}, 32'h1);
        check_val("f_valid_after_held", {31'h0, key_valid}, 32'h0);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check_val("f_valid", {31'h0, key_valid}, 32'h1);
        check_val("f_clear_shift", data, 32'h0000_000F);
        hold(kbit(15), 2);
        hold(16'h0, 4);

        // Reset during press debounce of "7"
        p0 = n_pulses;
        sync_scan();
        pressed = kbit(7);
        repeat (16) @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_val("mid_rst_col", {28'h0, col}, 32'hE);
        check_val("mid_rst_data", data, 32'h0);
        check_val("mid_rst_key_code", {28'h0, key_code}, 32'h0);
        check_val("mid_rst_key_valid", {31'h0, key_valid}, 32'h0);
        check_val("mid_rst_key_held", {31'h0, key_held}, 32'h0);
        exp_data = 32'h0;
        expect_key(4'h7, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 80) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_val("rst_relatch_cycles", 32'(n), 32'd33);
        hold(kbit(7), 2);
        hold(16'h0, 4);
        check_val("rst_pulses", 32'(n_pulses - p0), 32'd1);

        check_val("sb_leftover", 32'(exp_q.size()), 32'd0);
        check_val("total_pulses", 32'(n_pulses), 32'd22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
